// File: rtl/selector_regbank.sv
// 256 x DATA_W register bank addressed by a one-hot positional select vector.
// Malformed selects (zero or several bits set) are rejected and counted.
module selector_regbank #(
    parameter int DATA_W  = 8,
    parameter int ENTRIES = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ENTRIES-1:0] req_sel,
    input  logic               req_we,
    input  logic [DATA_W-1:0]  req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic [7:0]         rsp_index,
    output logic               rsp_err,
    output logic [7:0]         err_count
);

    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ENTRIES-1:0]  sel_q, sel_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   bank_q [ENTRIES];
    logic [DATA_W-1:0]   bank_d [ENTRIES];
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [IDX_W-1:0]    rsp_index_q, rsp_index_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                sel_seen;
    logic                sel_multi;
    logic [IDX_W-1:0]    hit_idx;
    logic                one_hot;

    // Single pass over the captured select: a second set bit marks it malformed.
    always_comb begin
        sel_seen  = 1'b0;
        sel_multi = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel_q[i]) begin
                sel_multi = sel_multi | sel_seen;
                sel_seen  = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
    end

    assign one_hot = sel_seen & ~sel_multi;

    always_comb begin
        // NOTE: every variable gets a hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        sel_d       = sel_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        bank_d      = bank_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_index_d = rsp_index_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_d   = req_sel;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = RESP;
                if (one_hot) begin
                    rsp_index_d = hit_idx;
                    rsp_err_d   = 1'b0;
                    if (we_q) begin
                        bank_d[hit_idx] = wdata_q;
                        rsp_rdata_d     = wdata_q;
                    end else begin
                        rsp_rdata_d = bank_q[hit_idx];
                    end
                end else begin
                    rsp_rdata_d = '0;
                    rsp_index_d = '0;
                    rsp_err_d   = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_index_q <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
            // NOTE: the bank is built from flops and must read 0 after reset, so it is cleared here.
            for (int i = 0; i < ENTRIES; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_index_q <= rsp_index_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
            bank_q      <= bank_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_index = rsp_index_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;

endmodule
